// File: rtl/verinject_injection_sequencer.sv
// Fault-injection sequencer: holds a schedule of (cycle, bit-index) entries
// and broadcasts each index on verinject__injector_state for one cycle at
// its scheduled cycle. Idle code 32'hFFFF_FFFF between faults; reset code
// 32'hFFFF_FFFE on request to clear the injectors' stored faults.
module verinject_injection_sequencer #(
  parameter int DEPTH      = 8,
  parameter int DEPTH_LOG2 = 3,
  parameter int CYCLE_W    = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [CYCLE_W-1:0] load_cycle,
  input  logic [31:0]        load_index,
  input  logic               start,
  input  logic               abort,
  input  logic               clear_faults,
  output logic [31:0]        verinject__injector_state,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic               busy,
  output logic               done,
  output logic               err_reserved,
  output logic               err_late
);

  localparam logic [31:0] IDLE_CODE  = 32'hFFFF_FFFF;
  localparam logic [31:0] RESET_CODE = 32'hFFFF_FFFE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CYCLE_W-1:0]    mem_cycle [DEPTH];
  logic [31:0]           mem_index [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [DEPTH_LOG2:0]   fifo_count;

  logic                  fifo_full, fifo_empty;
  logic                  accept, reserved, push, pop;
  logic [CYCLE_W-1:0]    head_cycle;
  logic [31:0]           head_index;

  logic [31:0]           out_q, out_d;
  logic [CYCLE_W-1:0]    cc_q, cc_d, cc_inc;
  logic                  late_set;

  assign fifo_full  = (fifo_count == (DEPTH_LOG2+1)'(DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign load_ready = !fifo_full && !abort;
  assign accept     = load_valid && load_ready;
  assign reserved   = (load_index == IDLE_CODE) || (load_index == RESET_CODE);
  assign push       = accept && !reserved;
  assign head_cycle = mem_cycle[rd_ptr];
  assign head_index = mem_index[rd_ptr];
  assign cc_inc     = (cc_q == '1) ? cc_q : cc_q + 1'b1;

  // Schedule storage: written on every accepted, non-reserved entry.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_cycle[wr_ptr] <= load_cycle;
      mem_index[wr_ptr] <= load_index;
    end
  end

  // FIFO pointers and occupancy; abort flushes the whole schedule.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else if (abort) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // State, broadcast, counter and sticky error registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      out_q        <= IDLE_CODE;
      cc_q         <= '0;
      err_reserved <= 1'b0;
      err_late     <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      cc_q         <= cc_d;
      err_reserved <= err_reserved | (accept && reserved);
      err_late     <= err_late | late_set;
    end
  end

  // Next state, broadcast value and pop decision. The head is compared with
  // the value cycle_count takes at this same edge, so an on-time entry is
  // visible exactly while cycle_count equals its stamp.
  always_comb begin
    state_d  = state_q;
    out_d    = IDLE_CODE;
    cc_d     = cc_q;
    pop      = 1'b0;
    late_set = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      cc_d    = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (clear_faults) begin
            out_d = RESET_CODE;
          end else if (start) begin
            cc_d = '0;
            if (fifo_empty) begin
              state_d = S_DONE;
            end else begin
              state_d = S_RUN;
              if (head_cycle == '0) begin
                out_d = head_index;
                pop   = 1'b1;
              end
            end
          end
        end
        S_RUN: begin
          cc_d = cc_inc;
          if (fifo_empty) begin
            state_d = S_DONE;
          end else if (head_cycle <= cc_inc) begin
            out_d    = head_index;
            pop      = 1'b1;
            late_set = (head_cycle < cc_inc);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign verinject__injector_state = out_q;
  assign cycle_count               = cc_q;
  assign busy                      = (state_q == S_RUN);
  assign done                      = (state_q == S_DONE);

endmodule
